atmos_light_frame_ctrl: RTL and testbench
=========================================

Name: atmos_light_frame_ctrl

Overview:
- Frame-level sequencer for the atmospheric-light estimator (min9/min3 running-max datapath with reciprocal LUTs).
- Clears the datapath's running maximum at frame start and gates its update enable over exactly one frame of 3x3 windows.
- Drains the datapath pipeline after the last window, then latches the final A_R/G/B and invA_R/G/B.
- Presents the latched values to the downstream transmission/recovery stage through a valid/ready handshake.

Parameters:
IMG_WIDTH, 512, windows per line
IMG_HEIGHT, 512, lines per frame
EN_DLY, 1, cycles from win_valid to datapath stage-3 register; acc_en/acc_clear delayed by this
PIPE_LAT, 3, cycles from accepted window to its effect on datapath A/invA outputs (EN_DLY + datapath registers)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low (asserted when 0)
frame_start  in  1  one-cycle pulse, start of a new frame
win_valid  in  1  3x3 RGB window on datapath inputs is valid this cycle
dp_A_R, dp_A_G, dp_A_B  in  8 each  datapath running A
dp_invA_R, dp_invA_G, dp_invA_B  in  9 each  datapath running 1/A
a_ready  in  1  downstream accepts latched result
err_clr  in  1  clears sticky error flags
acc_clear  out  1  synchronous clear for datapath running-max/A registers
acc_en  out  1  update enable for datapath stage-3 registers
A_R, A_G, A_B  out  8 each  latched frame A
invA_R, invA_G, invA_B  out  9 each  latched frame 1/A
a_valid  out  1  latched result available
frame_done  out  1  one-cycle pulse on latch
busy  out  1  high in CLEAR, ACCUM, DRAIN
err_frame  out  1  sticky: frame_start while busy
err_overrun  out  1  sticky: unconsumed result overwritten

Behaviour:
- Reset (rst==0 at an edge): state=IDLE; all outputs 0; window counter, drain counter and delay shift registers cleared. Applies identically mid-frame.
- TOTAL = IMG_WIDTH*IMG_HEIGHT. Counter width = clog2(TOTAL). Drain counter width = clog2(PIPE_LAT+1).
- States: IDLE, CLEAR, ACCUM, DRAIN.
  - IDLE: frame_start -> CLEAR. win_valid is ignored.
  - CLEAR: lasts one cycle. Raw clear=1; window counter := 0; -> ACCUM.
  - ACCUM: each cycle with win_valid=1 raises raw enable and increments the counter. Bubbles (win_valid=0) do not count.
    - win_valid with counter==TOTAL-1 -> DRAIN; drain counter := PIPE_LAT.
  - DRAIN: drain counter decrements each cycle; win_valid ignored, raw enable=0.
    - Cycle with drain counter==1: sample dp_* into A_*/invA_* regs, set a_valid, pulse frame_done, -> IDLE.
    - The latch occurs on the edge PIPE_LAT cycles after the edge that accepted the final window.
- acc_clear and acc_en are the raw clear/enable passed through an EN_DLY-stage shift register. EN_DLY=0 means combinational pass-through from registered state and win_valid.
- Handshake:
  - a_valid stays high and A_*/invA_* stay stable until the edge with a_valid&&a_ready, after which a_valid=0.
  - A new frame may start while a_valid=1; output regs are independent of the datapath.
  - Latch while a_valid&&!a_ready: overwrite with new values, keep a_valid=1, set err_overrun.
  - Latch coinciding with a_ready on the old result: take the new values, a_valid=1, no error.
- frame_start in CLEAR/ACCUM/DRAIN: ignored (no restart, counter unaffected); set err_frame.
- frame_start in the same cycle the FSM returns to IDLE is ignored without error; it must arrive while in IDLE.
- err_clr clears both sticky flags. If err_clr and a new error occur in the same cycle, the error wins.
- busy=1 exactly in CLEAR, ACCUM, DRAIN.

Test Plan:
- Hold rst=0 for 3 cycles mid-ACCUM (all other inputs toggling) -> all outputs 0, state IDLE; a following normal frame completes correctly.
- IMG_WIDTH=4, IMG_HEIGHT=2, PIPE_LAT=3, EN_DLY=1; frame_start then 8 contiguous win_valid -> acc_clear high one cycle after CLEAR; acc_en high 8 cycles, each 1 cycle late; datapath stub drives dp_A_R=0xC8, dp_invA_R=0x147 -> A_R=0xC8, invA_R=0x147 latched 3 edges after 8th window; frame_done pulse; a_valid held until a_ready.
- Same config, 8 win_valid with 1-3 cycle bubbles between -> exactly 8 acc_en pulses; latch timing relative to 8th valid unchanged.
- frame_start pulsed at window 5 of 8 -> no restart, err_frame=1 until err_clr, result latched after window 8.
- Two back-to-back frames with a_ready=0 and stub values 0x80 then 0xF0 -> A_R=0xF0, a_valid=1, err_overrun=1. Repeat with a_ready=1 on the second latch edge -> no error.
- win_valid pulses in IDLE and DRAIN -> acc_en stays 0 and window count is unaffected.

Source files
------------

// File: rtl/atmos_light_frame_ctrl_if.sv
// Result channel from the atmospheric-light frame controller to the
// transmission/recovery stage: latched A and 1/A plus a valid/ready handshake.
interface atmos_light_frame_ctrl_if;
  logic [7:0] A_R;
  logic [7:0] A_G;
  logic [7:0] A_B;
  logic [8:0] invA_R;
  logic [8:0] invA_G;
  logic [8:0] invA_B;
  logic       a_valid;
  logic       a_ready;

  // Producer side: drives the latched result and valid, observes ready.
  modport master (
    output A_R, A_G, A_B, invA_R, invA_G, invA_B, a_valid,
    input  a_ready
  );

  // Consumer side: observes the latched result and valid, drives ready.
  modport slave (
    input  A_R, A_G, A_B, invA_R, invA_G, invA_B, a_valid,
    output a_ready
  );
endinterface

// File: rtl/atmos_light_frame_ctrl.sv
// Frame-level sequencer for the atmospheric-light estimator.
// Clears the datapath running maximum at frame start, gates its update enable
// over exactly one frame of 3x3 windows, waits for the datapath pipeline to
// drain, then latches A and 1/A and offers them downstream via valid/ready.
module atmos_light_frame_ctrl #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int EN_DLY     = 1,
  parameter int PIPE_LAT   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       win_valid,
  input  logic [7:0] dp_A_R,
  input  logic [7:0] dp_A_G,
  input  logic [7:0] dp_A_B,
  input  logic [8:0] dp_invA_R,
  input  logic [8:0] dp_invA_G,
  input  logic [8:0] dp_invA_B,
  input  logic       err_clr,
  output logic       acc_clear,
  output logic       acc_en,
  output logic       frame_done,
  output logic       busy,
  output logic       err_frame,
  output logic       err_overrun,
  atmos_light_frame_ctrl_if.master res
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int DRN_W = $clog2(PIPE_LAT + 1);

  localparam logic [CNT_W-1:0] LAST_WIN  = CNT_W'(TOTAL - 1);
  localparam logic [DRN_W-1:0] DRAIN_LEN = DRN_W'(PIPE_LAT);
  localparam logic [DRN_W-1:0] DRAIN_ONE = DRN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_DRAIN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] win_cnt;
  logic [DRN_W-1:0] drain_cnt;

  logic [7:0] a_r_q, a_g_q, a_b_q;
  logic [8:0] inv_r_q, inv_g_q, inv_b_q;
  logic       a_valid_q;

  // Undelayed clear/enable, decoded from the registered state.
  logic raw_clr;
  logic raw_en;
  logic drain_last;
  logic take;
  logic frame_err_set;
  logic overrun_set;

  assign raw_clr    = (state == S_CLEAR);
  assign raw_en     = (state == S_ACCUM) && win_valid;
  assign drain_last = (state == S_DRAIN) && (drain_cnt == DRAIN_ONE);
  assign take       = a_valid_q && res.a_ready;

  // A frame_start on the very cycle the FSM heads back to IDLE is dropped
  // silently; anywhere else while busy it is a protocol error.
  assign frame_err_set = frame_start && (state != S_IDLE) && !drain_last;
  assign overrun_set   = drain_last && a_valid_q && !res.a_ready;

  // Align acc_clear/acc_en with the datapath stage-3 register.
  generate
    if (EN_DLY == 0) begin : g_no_dly
      assign acc_clear = raw_clr;
      assign acc_en    = raw_en;
    end else begin : g_dly
      logic [EN_DLY-1:0] clr_sr;
      logic [EN_DLY-1:0] en_sr;

      // Shift raw clear/enable through EN_DLY stages.
      always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch
        // rather than in the sensitivity list.
        if (!rst) begin
          clr_sr <= '0;
          en_sr  <= '0;
        end else begin
          clr_sr[0] <= raw_clr;
          en_sr[0]  <= raw_en;
          for (int i = 1; i < EN_DLY; i++) begin
            clr_sr[i] <= clr_sr[i-1];
            en_sr[i]  <= en_sr[i-1];
          end
        end
      end

      assign acc_clear = clr_sr[EN_DLY-1];
      assign acc_en    = en_sr[EN_DLY-1];
    end
  endgenerate

  // Frame FSM, counters, result registers, handshake and sticky errors.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      win_cnt     <= '0;
      drain_cnt   <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      a_valid_q   <= 1'b0;
      a_r_q       <= '0;
      a_g_q       <= '0;
      a_b_q       <= '0;
      inv_r_q     <= '0;
      inv_g_q     <= '0;
      inv_b_q     <= '0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here; later assignments in
      // this block override earlier defaults for the same edge.
      frame_done <= 1'b0;
      if (take) begin
        a_valid_q <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state <= S_CLEAR;
            busy  <= 1'b1;
          end
        end

        S_CLEAR: begin
          win_cnt <= '0;
          state   <= S_ACCUM;
        end

        S_ACCUM: begin
          if (win_valid) begin
            win_cnt <= win_cnt + 1'b1;
            if (win_cnt == LAST_WIN) begin
              drain_cnt <= DRAIN_LEN;
              state     <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          drain_cnt <= drain_cnt - 1'b1;
          if (drain_cnt == DRAIN_ONE) begin
            a_r_q      <= dp_A_R;
            a_g_q      <= dp_A_G;
            a_b_q      <= dp_A_B;
            inv_r_q    <= dp_invA_R;
            inv_g_q    <= dp_invA_G;
            inv_b_q    <= dp_invA_B;
            a_valid_q  <= 1'b1;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A new error in the same cycle as err_clr takes precedence.
      if (frame_err_set) begin
        err_frame <= 1'b1;
      end else if (err_clr) begin
        err_frame <= 1'b0;
      end

      if (overrun_set) begin
        err_overrun <= 1'b1;
      end else if (err_clr) begin
        err_overrun <= 1'b0;
      end
    end
  end

  assign res.A_R     = a_r_q;
  assign res.A_G     = a_g_q;
  assign res.A_B     = a_b_q;
  assign res.invA_R  = inv_r_q;
  assign res.invA_G  = inv_g_q;
  assign res.invA_B  = inv_b_q;
  assign res.a_valid = a_valid_q;

endmodule

// File: tb/tb_atmos_light_frame_ctrl.sv
// Directed bench for atmos_light_frame_ctrl with a 4x2 frame, EN_DLY=1,
// PIPE_LAT=3. The datapath is a stub whose outputs show a decoy value except
// on the cycle before the expected latch edge.
module tb_atmos_light_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int ED = 1;
  localparam int PL = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       win_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] dp_A_R = '0, dp_A_G = '0, dp_A_B = '0;
  logic [8:0] dp_invA_R = '0, dp_invA_G = '0, dp_invA_B = '0;
  logic       acc_clear, acc_en, frame_done, busy, err_frame, err_overrun;

  atmos_light_frame_ctrl_if res_if ();

  int n_tests = 0;
  int n_fail  = 0;
  int en_seen;
  int clr_seen;

  atmos_light_frame_ctrl #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .EN_DLY    (ED),
    .PIPE_LAT  (PL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .win_valid  (win_valid),
    .dp_A_R     (dp_A_R),
    .dp_A_G     (dp_A_G),
    .dp_A_B     (dp_A_B),
    .dp_invA_R  (dp_invA_R),
    .dp_invA_G  (dp_invA_G),
    .dp_invA_B  (dp_invA_B),
    .err_clr    (err_clr),
    .acc_clear  (acc_clear),
    .acc_en     (acc_en),
    .frame_done (frame_done),
    .busy       (busy),
    .err_frame  (err_frame),
    .err_overrun(err_overrun),
    .res        (res_if)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    en_seen  += int'(acc_en);
    clr_seen += int'(acc_clear);
  endtask

  task automatic set_dp(input logic [7:0] a, input logic [8:0] ia);
    dp_A_R    = a;
    dp_A_G    = a + 8'd1;
    dp_A_B    = a + 8'd2;
    dp_invA_R = ia;
    dp_invA_G = ia + 9'd1;
    dp_invA_B = ia + 9'd2;
  endtask

  // One frame of 8 windows; returns the edge count from the 8th accepted
  // window to frame_done (0 if it never came).
  task automatic run_frame(input logic [7:0] a, input logic [8:0] ia,
                           input bit bubbles, input bit fs_mid,
                           input bit drain_noise, input bit ready_at_latch,
                           output bit clr_ok, output int lat);
    int g;
    en_seen  = 0;
    clr_seen = 0;
    lat      = 0;
    set_dp(8'h11, 9'h011);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_in_clear got %b required 1", busy);
    end
    tick();
    clr_ok = acc_clear;
    for (int w = 0; w < 8; w++) begin
      win_valid   = 1'b1;
      frame_start = fs_mid && (w == 4);
      tick();
      win_valid   = 1'b0;
      frame_start = 1'b0;
      if (bubbles && w < 7) begin
        g = $urandom_range(1, 3);
        repeat (g) tick();
      end
    end
    for (int i = 1; i <= 20; i++) begin
      win_valid = drain_noise;
      if (i == PL) begin
        set_dp(a, ia);
        if (ready_at_latch) res_if.a_ready = 1'b1;
      end
      tick();
      if (frame_done === 1'b1) begin
        lat = i;
        break;
      end
    end
    win_valid      = 1'b0;
    res_if.a_ready = 1'b0;
    set_dp(8'h22, 9'h022);
  endtask

  task automatic consume();
    res_if.a_ready = 1'b1;
    tick();
    res_if.a_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_tests++;
    if ({acc_clear, acc_en, frame_done, busy, err_frame, err_overrun, res_if.a_valid,
         res_if.A_R, res_if.A_G, res_if.A_B, res_if.invA_R, res_if.invA_G, res_if.invA_B} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b a_valid=%b A_R=%h required all zero", busy, res_if.a_valid, res_if.A_R);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit clr_ok;
    int lat;
    run_frame(8'hC8, 9'h147, 1'b0, 1'b0, 1'b0, 1'b0, clr_ok, lat);
    n_tests++;
    if (clr_ok !== 1'b1) begin n_fail++; $display("FAIL basic_clr_timing got %b required 1", clr_ok); end
    n_tests++;
    if (clr_seen != 1) begin n_fail++; $display("FAIL basic_clr_count got %0d required 1", clr_seen); end
    n_tests++;
    if (en_seen != 8) begin n_fail++; $display("FAIL basic_en_count got %0d required 8", en_seen); end
    n_tests++;
    if (lat != PL) begin n_fail++; $display("FAIL basic_latency got %0d required %0d", lat, PL); end
    n_tests++;
    if (res_if.A_R !== 8'hC8) begin n_fail++; $display("FAIL basic_A_R got %h required c8", res_if.A_R); end
    n_tests++;
    if (res_if.invA_R !== 9'h147) begin n_fail++; $display("FAIL basic_invA_R got %h required 147", res_if.invA_R); end
    n_tests++;
    if ({res_if.A_G, res_if.A_B, res_if.invA_G, res_if.invA_B} !== {8'hC9, 8'hCA, 9'h148, 9'h149}) begin
      n_fail++;
      $display("FAIL basic_GB got %h %h %h %h required c9 ca 148 149", res_if.A_G, res_if.A_B, res_if.invA_G, res_if.invA_B);
    end
    n_tests++;
    if ({res_if.a_valid, busy, err_overrun} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_flags got valid/busy/ovr=%b%b%b required 100", res_if.a_valid, busy, err_overrun);
    end
    repeat (3) tick();
    n_tests++;
    if ({res_if.a_valid, frame_done, res_if.A_R} !== {1'b1, 1'b0, 8'hC8}) begin
      n_fail++;
      $display("FAIL basic_hold got valid=%b done=%b A_R=%h required 1 0 c8", res_if.a_valid, frame_done, res_if.A_R);
    end
    consume();
    n_tests++;
    if (res_if.a_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consume got %b required 0", res_if.a_valid); end
  endtask

  task automatic test_bubbles();
    bit clr_ok;
    int lat;
    run_frame(8'h5A, 9'h1A5, 1'b1, 1'b0, 1'b0, 1'b0, clr_ok, lat);
    n_tests++;
    if (en_seen != 8) begin n_fail++; $display("FAIL bubbles_en_count got %0d required 8", en_seen); end
    n_tests++;
    if (lat != PL) begin n_fail++; $display("FAIL bubbles_latency got %0d required %0d", lat, PL); end
    n_tests++;
    if (res_if.A_R !== 8'h5A) begin n_fail++; $display("FAIL bubbles_A_R got %h required 5a", res_if.A_R); end
    consume();
  endtask

  task automatic test_frame_err();
    bit clr_ok;
    int lat;
    run_frame(8'h3C, 9'h0C3, 1'b0, 1'b1, 1'b0, 1'b0, clr_ok, lat);
    n_tests++;
    if (lat != PL || en_seen != 8) begin
      n_fail++;
      $display("FAIL ferr_no_restart got lat=%0d en=%0d required %0d 8", lat, en_seen, PL);
    end
    n_tests++;
    if (res_if.A_R !== 8'h3C) begin n_fail++; $display("FAIL ferr_A_R got %h required 3c", res_if.A_R); end
    repeat (2) tick();
    n_tests++;
    if (err_frame !== 1'b1) begin n_fail++; $display("FAIL ferr_sticky got %b required 1", err_frame); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_tests++;
    if (err_frame !== 1'b0) begin n_fail++; $display("FAIL ferr_clear got %b required 0", err_frame); end
    consume();
  endtask

  task automatic test_back_to_back();
    bit clr_ok;
    int lat;
    run_frame(8'h80, 9'h100, 1'b0, 1'b0, 1'b0, 1'b0, clr_ok, lat);
    run_frame(8'hF0, 9'h1F0, 1'b0, 1'b0, 1'b0, 1'b0, clr_ok, lat);
    n_tests++;
    if ({res_if.A_R, res_if.invA_R, res_if.a_valid, err_overrun} !== {8'hF0, 9'h1F0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_overrun got A_R=%h invA_R=%h valid=%b ovr=%b required f0 1f0 1 1",
               res_if.A_R, res_if.invA_R, res_if.a_valid, err_overrun);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    consume();
    run_frame(8'h80, 9'h100, 1'b0, 1'b0, 1'b0, 1'b0, clr_ok, lat);
    run_frame(8'hF0, 9'h1F0, 1'b0, 1'b0, 1'b0, 1'b1, clr_ok, lat);
    n_tests++;
    if ({res_if.A_R, res_if.a_valid, err_overrun} !== {8'hF0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_ready_on_latch got A_R=%h valid=%b ovr=%b required f0 1 0",
               res_if.A_R, res_if.a_valid, err_overrun);
    end
  endtask

  task automatic test_reset_mid();
    bit clr_ok;
    int lat;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    win_valid = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      win_valid      = k[0];
      frame_start    = ~k[0];
      res_if.a_ready = k[0];
      err_clr        = ~k[0];
      tick();
    end
    n_tests++;
    if ({acc_clear, acc_en, frame_done, busy, err_frame, err_overrun, res_if.a_valid,
         res_if.A_R, res_if.invA_R} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got busy=%b a_valid=%b A_R=%h required all zero", busy, res_if.a_valid, res_if.A_R);
    end
    win_valid      = 1'b0;
    frame_start    = 1'b0;
    res_if.a_ready = 1'b0;
    err_clr        = 1'b0;
    rst            = 1'b1;
    tick();
    run_frame(8'h77, 9'h0A7, 1'b0, 1'b0, 1'b0, 1'b0, clr_ok, lat);
    n_tests++;
    if ({lat == PL, en_seen == 8, res_if.A_R == 8'h77} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_mid_frame got lat=%0d en=%0d A_R=%h required %0d 8 77", lat, en_seen, res_if.A_R, PL);
    end
    consume();
  endtask

  task automatic test_ignored_windows();
    bit clr_ok;
    int lat;
    en_seen   = 0;
    win_valid = 1'b1;
    repeat (5) tick();
    win_valid = 1'b0;
    tick();
    n_tests++;
    if (en_seen != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_windows got en=%0d busy=%b required 0 0", en_seen, busy);
    end
    run_frame(8'h9D, 9'h19D, 1'b0, 1'b0, 1'b1, 1'b0, clr_ok, lat);
    n_tests++;
    if (en_seen != 8 || lat != PL) begin
      n_fail++;
      $display("FAIL drain_windows got en=%0d lat=%0d required 8 %0d", en_seen, lat, PL);
    end
    n_tests++;
    if (res_if.A_R !== 8'h9D) begin n_fail++; $display("FAIL drain_windows_A_R got %h required 9d", res_if.A_R); end
    consume();
  endtask

  initial begin
    res_if.a_ready = 1'b0;
    en_seen        = 0;
    clr_seen       = 0;
    test_reset();
    test_basic();
    test_bubbles();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_ignored_windows();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
